// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - two-requester arbiter/sequencer in front of a 4-bit mode counter
// Optional macro ROUND_ROBIN_EN selects alternating tie-break instead of fixed priority to requester 0.
module counter_arbiter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [1:0] MODO0,
  input  logic [1:0] MODO1,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] STEPS0,
  input  logic [3:0] STEPS1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [3:0] WRAPS,
  output logic       CNT_EN,
  output logic       CNT_RESET,
  output logic [1:0] CNT_MODO,
  output logic [3:0] CNT_D,
  input  logic       CNT_RCO
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] mode_q, mode_d;
  logic [3:0] dval_q, dval_d;
  logic [3:0] steps_q, steps_d;
  logic       run_prev_q, run_prev_d;
  logic [3:0] wraps_q, wraps_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_reset_q, cnt_reset_d;
  logic [1:0] cnt_modo_q, cnt_modo_d;
  logic [3:0] cnt_d_q, cnt_d_d;
  logic       winner;
  logic       busy;
`ifdef ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    mode_d   = mode_q;
    dval_d   = dval_q;
    steps_d  = steps_q;
    wraps_d  = wraps_q;
    winner   = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_d   = last_q;
    if (REQ0 && REQ1) winner = ~last_q;
    else              winner = REQ1;
`else
    if (!REQ0) winner = REQ1;
`endif

    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d = S_LOAD;
          owner_d = winner;
          mode_d  = winner ? MODO1 : MODO0;
          dval_d  = winner ? D1 : D0;
          steps_d = winner ? STEPS1 : STEPS0;
`ifdef ROUND_ROBIN_EN
          last_d  = winner;
`endif
        end
      end
      S_LOAD: state_d = (steps_q != 4'd0) ? S_RUN : S_FLUSH;
      S_RUN: begin
        steps_d = steps_q - 4'd1;
        if (steps_q == 4'd1) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    // RCO seen this cycle belongs to a step enabled in the previous cycle
    run_prev_d = (state_q == S_RUN);
    if (CNT_RCO && run_prev_q && (wraps_q != 4'd15)) wraps_d = wraps_q + 4'd1;
    if (state_d == S_LOAD) wraps_d = 4'd0;

    busy        = (state_d == S_LOAD) || (state_d == S_RUN) ||
                  (state_d == S_FLUSH) || (state_d == S_DONE);
    gnt0_d      = busy && !owner_d;
    gnt1_d      = busy && owner_d;
    done0_d     = (state_d == S_DONE) && !owner_d;
    done1_d     = (state_d == S_DONE) && owner_d;
    cnt_en_d    = (state_d == S_LOAD) || (state_d == S_RUN);
    cnt_reset_d = (state_d == S_INIT);
    cnt_modo_d  = 2'b00;
    cnt_d_d     = 4'd0;
    if (state_d == S_LOAD) begin
      cnt_modo_d = 2'b11;
      cnt_d_d    = dval_d;
    end else if (state_d == S_RUN) begin
      cnt_modo_d = mode_d;
      cnt_d_d    = dval_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_INIT;
      owner_q     <= 1'b0;
      mode_q      <= 2'b00;
      dval_q      <= 4'd0;
      steps_q     <= 4'd0;
      run_prev_q  <= 1'b0;
      wraps_q     <= 4'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_reset_q <= 1'b1;
      cnt_modo_q  <= 2'b00;
      cnt_d_q     <= 4'd0;
`ifdef ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      dval_q      <= dval_d;
      steps_q     <= steps_d;
      run_prev_q  <= run_prev_d;
      wraps_q     <= wraps_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      cnt_en_q    <= cnt_en_d;
      cnt_reset_q <= cnt_reset_d;
      cnt_modo_q  <= cnt_modo_d;
      cnt_d_q     <= cnt_d_d;
`ifdef ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign GNT0      = gnt0_q;
  assign GNT1      = gnt1_q;
  assign DONE0     = done0_q;
  assign DONE1     = done1_q;
  assign WRAPS     = wraps_q;
  assign CNT_EN    = cnt_en_q;
  assign CNT_RESET = cnt_reset_q;
  assign CNT_MODO  = cnt_modo_q;
  assign CNT_D     = cnt_d_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - randomized self-checking bench for counter_arbiter
module tb_counter_arbiter;
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [1:0] MODO0 = 2'b00, MODO1 = 2'b00;
  logic [3:0] D0 = 4'd0, D1 = 4'd0, STEPS0 = 4'd0, STEPS1 = 4'd0;
  logic       GNT0, GNT1, DONE0, DONE1, CNT_EN, CNT_RESET, CNT_RCO;
  logic [3:0] WRAPS, CNT_D;
  logic [1:0] CNT_MODO;
  logic [3:0] cnt_val;
  logic       cnt_rco;
  int         checks = 0;
  int         failures = 0;
  int         last_owner = 1;

  always #5 CLK = ~CLK;

  counter_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1),
    .MODO0(MODO0), .MODO1(MODO1), .D0(D0), .D1(D1),
    .STEPS0(STEPS0), .STEPS1(STEPS1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .WRAPS(WRAPS), .CNT_EN(CNT_EN), .CNT_RESET(CNT_RESET),
    .CNT_MODO(CNT_MODO), .CNT_D(CNT_D), .CNT_RCO(CNT_RCO)
  );

  // Counter being driven: RCO is a registered carry/borrow of the last enabled step
  always @(posedge CLK) begin
    if (CNT_RESET) begin
      cnt_val <= 4'd0;
      cnt_rco <= 1'b0;
    end else if (CNT_EN) begin
      case (CNT_MODO)
        2'b00: {cnt_rco, cnt_val} <= {1'b0, cnt_val} + 5'd3;
        2'b01: begin cnt_rco <= (cnt_val == 4'd0); cnt_val <= cnt_val - 4'd1; end
        2'b10: {cnt_rco, cnt_val} <= {1'b0, cnt_val} + 5'd1;
        default: begin cnt_rco <= 1'b0; cnt_val <= CNT_D; end
      endcase
    end else begin
      cnt_rco <= 1'b0;
    end
  end
  assign CNT_RCO = cnt_rco;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void ref_txn(input int d, input int mode, input int steps,
                                  output int wraps, output int fin);
    int v, t;
    v = d;
    wraps = 0;
    for (int i = 0; i < steps; i++) begin
      if (mode == 3) v = d;
      else begin
        t = v + ((mode == 0) ? 3 : ((mode == 2) ? 1 : -1));
        if (t > 15 || t < 0) wraps++;
        v = (t + 16) % 16;
      end
    end
    if (wraps > 15) wraps = 15;
    fin = v;
  endfunction

  task automatic do_txn(input logic [1:0] reqs, input bit hold, input bit mess);
    int w, d, m, s, ew, ef, ncyc, nen, ndone, viol;
    bit seen;
    if (reqs == 2'b11) begin
`ifdef ROUND_ROBIN_EN
      w = 1 - last_owner;
`else
      w = 0;
`endif
    end else begin
      w = reqs[1] ? 1 : 0;
    end
    last_owner = w;
    d = w ? int'(D1) : int'(D0);
    m = w ? int'(MODO1) : int'(MODO0);
    s = w ? int'(STEPS1) : int'(STEPS0);
    ref_txn(d, m, s, ew, ef);
    REQ0 = reqs[0];
    REQ1 = reqs[1];
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge CLK);
      seen = GNT0 | GNT1;
    end
    check("grant_seen", int'(seen), 1);
    if (!seen) begin
      REQ0 = 1'b0;
      REQ1 = 1'b0;
      return;
    end
    check("owner", int'(GNT1), w);
    if (mess) begin
      D0 = 4'($urandom); D1 = 4'($urandom);
      MODO0 = 2'($urandom); MODO1 = 2'($urandom);
      STEPS0 = 4'($urandom); STEPS1 = 4'($urandom);
      if ($urandom_range(1) == 1) begin REQ0 = 1'b0; REQ1 = 1'b0; end
    end
    ncyc = 0; nen = 0; ndone = 0; viol = 0;
    for (int k = 0; k < 40; k++) begin
      if (GNT0 && GNT1) viol++;
      if ((DONE0 && !GNT0) || (DONE1 && !GNT1)) viol++;
      if (GNT0 | GNT1) ncyc++;
      if (CNT_EN) nen++;
      if (DONE0 | DONE1) begin
        ndone++;
        break;
      end
      @(negedge CLK);
    end
    check("gnt_cycles", ncyc, s + 3);
    check("en_cycles", nen, s + 1);
    check("done_seen", ndone, 1);
    check("done_owner", int'(DONE1), w);
    check("wraps", int'(WRAPS), ew);
    check("counter_final", int'(cnt_val), ef);
    check("exclusive", viol, 0);
    if (!hold) begin REQ0 = 1'b0; REQ1 = 1'b0; end
    @(negedge CLK);
    check("idle_gap", int'({GNT0, GNT1, DONE0, DONE1, CNT_EN}), 0);
    check("idle_drive", int'({CNT_MODO, CNT_D}), 0);
  endtask

  task automatic reset_release();
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("init_cnt_reset", int'(CNT_RESET), 1);
    @(negedge CLK);
    check("idle_cnt_reset", int'(CNT_RESET), 0);
    last_owner = 1;
  endtask

  initial begin
    int ndone;
    bit seen;
    #1 RESET = 1'b1;
    @(negedge CLK);
    check("rst_cnt_reset", int'(CNT_RESET), 1);
    check("rst_outputs", int'({GNT0, GNT1, DONE0, DONE1, WRAPS, CNT_EN, CNT_MODO, CNT_D}), 0);
    reset_release();

    D0 = 4'd14; MODO0 = 2'b10; STEPS0 = 4'd3;
    do_txn(2'b01, 1'b0, 1'b0);
    D1 = 4'd2; MODO1 = 2'b01; STEPS1 = 4'd0;
    do_txn(2'b10, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      D0 = 4'($urandom); D1 = 4'($urandom);
      MODO0 = 2'($urandom); MODO1 = 2'($urandom);
      STEPS0 = 4'($urandom); STEPS1 = 4'($urandom);
      do_txn(2'($urandom_range(1, 3)), 1'b0, 1'($urandom_range(1)));
    end

    D0 = 4'd3; MODO0 = 2'b10; STEPS0 = 4'd2;
    D1 = 4'd9; MODO1 = 2'b01; STEPS1 = 4'd1;
    for (int i = 0; i < 4; i++) do_txn(2'b11, 1'b1, 1'b0);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);

    D0 = 4'd15; MODO0 = 2'b00; STEPS0 = 4'd15;
    do_txn(2'b01, 1'b0, 1'b0);
    D0 = 4'd5; MODO0 = 2'b11; STEPS0 = 4'd6;
    do_txn(2'b01, 1'b0, 1'b0);

    D0 = 4'd7; MODO0 = 2'b10; STEPS0 = 4'd8;
    REQ0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge CLK);
      seen = GNT0;
    end
    check("rr_grant_seen", int'(seen), 1);
    repeat (3) @(negedge CLK);
    check("mid_run_en", int'(CNT_EN), 1);
    #2 RESET = 1'b1;
    #1;
    check("async_cnt_reset", int'(CNT_RESET), 1);
    check("async_outputs", int'({GNT0, GNT1, DONE0, DONE1, WRAPS, CNT_EN, CNT_MODO, CNT_D}), 0);
    REQ0 = 1'b0;
    ndone = 0;
    repeat (2) begin
      @(negedge CLK);
      if (DONE0 | DONE1) ndone++;
    end
    check("no_done_in_reset", ndone, 0);
    reset_release();
    D1 = 4'd1; MODO1 = 2'b10; STEPS1 = 4'd2;
    do_txn(2'b10, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
